// File: rtl/microseq_ctrl_if.sv
// Interface bundling the microsequencer's control pulses, load ports, datapath inputs and outputs.
// stall_i exists only when MICROSEQ_STALL_EN is defined.
interface microseq_ctrl_if #(
    parameter int UADDR_W     = 5,
    parameter int OPC_W       = 4,
    parameter int CTRL_W      = 16,
    parameter int STACK_DEPTH = 4
);
    localparam int UWORD_W = CTRL_W + 3 + UADDR_W;
    localparam int SP_W    = $clog2(STACK_DEPTH) + 1;

    logic               start;
    logic               stop;
    logic               clear_fault;
    logic               cs_we;
    logic [UADDR_W-1:0] cs_waddr;
    logic [UWORD_W-1:0] cs_wdata;
    logic               map_we;
    logic [OPC_W-1:0]   map_waddr;
    logic [UADDR_W-1:0] map_wdata;
    logic [OPC_W-1:0]   opcode_i;
    logic               flag_z_i;
    logic               flag_n_i;
`ifdef MICROSEQ_STALL_EN
    logic               stall_i;
`endif
    logic [CTRL_W-1:0]  ctrl_o;
    logic [UADDR_W-1:0] upc_o;
    logic [SP_W-1:0]    sp_o;
    logic               busy_o;
    logic               fault_o;

    modport master (
        output start, stop, clear_fault,
        output cs_we, cs_waddr, cs_wdata,
        output map_we, map_waddr, map_wdata,
        output opcode_i, flag_z_i, flag_n_i,
`ifdef MICROSEQ_STALL_EN
        output stall_i,
`endif
        input  ctrl_o, upc_o, sp_o, busy_o, fault_o
    );

    modport slave (
        input  start, stop, clear_fault,
        input  cs_we, cs_waddr, cs_wdata,
        input  map_we, map_waddr, map_wdata,
        input  opcode_i, flag_z_i, flag_n_i,
`ifdef MICROSEQ_STALL_EN
        input  stall_i,
`endif
        output ctrl_o, upc_o, sp_o, busy_o, fault_o
    );
endinterface

// File: rtl/microseq_ctrl.sv
// Writable-control-store microprogram sequencer with opcode map, branch ops and return stack.
// Optional memory wait-state stall via MICROSEQ_STALL_EN.
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | halted; control store and map table may be loaded
// S_RUN   | sequencing one microword per cycle, ctrl_o driven
// S_FAULT | stack overflow/underflow trapped; waits for clear_fault
module microseq_ctrl #(
    parameter int UADDR_W     = 5,
    parameter int OPC_W       = 4,
    parameter int CTRL_W      = 16,
    parameter int STACK_DEPTH = 4
) (
    input logic            clk,
    input logic            rst,
    microseq_ctrl_if.slave bus
);
    localparam int UWORD_W   = CTRL_W + 3 + UADDR_W;
    localparam int SP_W      = $clog2(STACK_DEPTH) + 1;
    localparam int CS_DEPTH  = 2 ** UADDR_W;
    localparam int MAP_DEPTH = 2 ** OPC_W;
    // Sized to the full sp range so any sp value indexes it without truncation.
    localparam int STK_N     = 2 ** SP_W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FAULT = 2'd2;

    localparam logic [2:0] OP_INC   = 3'd0;
    localparam logic [2:0] OP_JMP   = 3'd1;
    localparam logic [2:0] OP_MAP   = 3'd2;
    localparam logic [2:0] OP_BRZ   = 3'd3;
    localparam logic [2:0] OP_BRN   = 3'd4;
    localparam logic [2:0] OP_CALL  = 3'd5;
    localparam logic [2:0] OP_RET   = 3'd6;
    localparam logic [2:0] OP_FETCH = 3'd7;

    logic [UWORD_W-1:0] cs    [CS_DEPTH];
    logic [UADDR_W-1:0] map   [MAP_DEPTH];
    logic [UADDR_W-1:0] stack [STK_N];

    logic [1:0]         state, state_nxt;
    logic [UADDR_W-1:0] upc, upc_nxt, upc_inc;
    logic [SP_W-1:0]    sp, sp_nxt, sp_dec;
    logic               push;
    logic               stall;

    logic [UWORD_W-1:0] uword;
    logic [CTRL_W-1:0]  uctrl;
    logic [2:0]         uop;
    logic [UADDR_W-1:0] utgt;

`ifdef MICROSEQ_STALL_EN
    assign stall = bus.stall_i;
`else
    assign stall = 1'b0;
`endif

    assign uword   = cs[upc];
    assign uctrl   = uword[UWORD_W-1 -: CTRL_W];
    assign uop     = uword[UADDR_W+2:UADDR_W];
    assign utgt    = uword[UADDR_W-1:0];
    assign upc_inc = upc + UADDR_W'(1);
    assign sp_dec  = sp - SP_W'(1);

    always_comb begin
        state_nxt = state;
        upc_nxt   = upc;
        sp_nxt    = sp;
        push      = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start && !bus.stop) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (bus.stop) begin
                    state_nxt = S_IDLE;
                end else if (!stall) begin
                    case (uop)
                        OP_INC:  upc_nxt = upc_inc;
                        OP_JMP:  upc_nxt = utgt;
                        OP_MAP:  upc_nxt = map[bus.opcode_i];
                        OP_BRZ:  upc_nxt = bus.flag_z_i ? utgt : upc_inc;
                        OP_BRN:  upc_nxt = bus.flag_n_i ? utgt : upc_inc;
                        OP_CALL: begin
                            if (sp == SP_W'(STACK_DEPTH)) begin
                                state_nxt = S_FAULT;
                            end else begin
                                push    = 1'b1;
                                sp_nxt  = sp + SP_W'(1);
                                upc_nxt = utgt;
                            end
                        end
                        OP_RET: begin
                            if (sp == '0) begin
                                state_nxt = S_FAULT;
                            end else begin
                                sp_nxt  = sp_dec;
                                upc_nxt = stack[sp_dec];
                            end
                        end
                        default: upc_nxt = '0;
                    endcase
                end
            end
            S_FAULT: begin
                if (bus.clear_fault) begin
                    state_nxt = S_IDLE;
                    upc_nxt   = '0;
                    sp_nxt    = '0;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            upc   <= '0;
            sp    <= '0;
            for (int i = 0; i < MAP_DEPTH; i++) map[i] <= '0;
        end else begin
            state <= state_nxt;
            upc   <= upc_nxt;
            sp    <= sp_nxt;
            if (state == S_IDLE && bus.map_we) map[bus.map_waddr] <= bus.map_wdata;
        end
    end

    // Control store and stack RAM are intentionally not reset; sp alone tracks stack validity.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && bus.cs_we) cs[bus.cs_waddr] <= bus.cs_wdata;
        if (push) stack[sp] <= upc_inc;
    end

    assign bus.ctrl_o  = (state == S_RUN) ? uctrl : '0;
    assign bus.upc_o   = upc;
    assign bus.sp_o    = sp;
    assign bus.busy_o  = (state == S_RUN);
    assign bus.fault_o = (state == S_FAULT);
endmodule

// File: tb/tb_microseq_ctrl.sv
// Directed testbench for microseq_ctrl: sequencing, branches, call/return, faults, reset, stall.
module tb_microseq_ctrl;
    localparam logic [2:0] INC = 3'd0, JMP = 3'd1, MAP = 3'd2, BRZ = 3'd3;
    localparam logic [2:0] BRN = 3'd4, CALL = 3'd5, RET = 3'd6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    microseq_ctrl_if #(.UADDR_W(5), .OPC_W(4), .CTRL_W(16), .STACK_DEPTH(4)) bus ();

    microseq_ctrl #(.UADDR_W(5), .OPC_W(4), .CTRL_W(16), .STACK_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] uw(input logic [15:0] c, input logic [2:0] op, input logic [4:0] t);
        return {c, op, t};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cs_wr(input logic [4:0] a, input logic [23:0] d);
        bus.cs_we = 1'b1; bus.cs_waddr = a; bus.cs_wdata = d;
        step();
        bus.cs_we = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic do_stop();
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
    endtask

    initial begin
        bus.start = 0; bus.stop = 0; bus.clear_fault = 0;
        bus.cs_we = 0; bus.cs_waddr = '0; bus.cs_wdata = '0;
        bus.map_we = 0; bus.map_waddr = '0; bus.map_wdata = '0;
        bus.opcode_i = '0; bus.flag_z_i = 0; bus.flag_n_i = 0;
`ifdef MICROSEQ_STALL_EN
        bus.stall_i = 0;
`endif
        #3;
        chk("rst_upc",   bus.upc_o,   0);
        chk("rst_sp",    bus.sp_o,    0);
        chk("rst_ctrl",  bus.ctrl_o,  0);
        chk("rst_busy",  bus.busy_o,  0);
        chk("rst_fault", bus.fault_o, 0);
        step();
        rst = 1'b0;

        // Basic sequencing, with a cs and map write landing in the same cycle
        cs_wr(0, uw(16'h0001, INC, 0));
        cs_wr(1, uw(16'h0002, MAP, 0));
        bus.map_we = 1'b1; bus.map_waddr = 4'd3; bus.map_wdata = 5'd8;
        cs_wr(8, uw(16'h0004, JMP, 0));
        bus.map_we = 1'b0;
        bus.opcode_i = 4'd3;
        do_start();
        chk("seq_busy",  bus.busy_o, 1);
        chk("seq_upc0",  bus.upc_o,  0);
        chk("seq_ctrl0", bus.ctrl_o, 16'h0001);
        step();
        chk("seq_upc1",  bus.upc_o,  1);
        chk("seq_ctrl1", bus.ctrl_o, 16'h0002);
        step();
        chk("seq_upc8",  bus.upc_o,  8);
        chk("seq_ctrl8", bus.ctrl_o, 16'h0004);
        step();
        chk("seq_upc0b", bus.upc_o,  0);
        chk("seq_ctrl0b", bus.ctrl_o, 16'h0001);
        step();
        chk("seq_upc1b", bus.upc_o,  1);
        do_stop();
        chk("stop_busy", bus.busy_o, 0);
        chk("stop_ctrl", bus.ctrl_o, 0);
        chk("stop_upc",  bus.upc_o,  1);

        // Branches, then call/return and return-stack underflow
        cs_wr(1,  uw(16'h0002, JMP, 4));
        cs_wr(4,  uw(16'h0040, BRZ, 10));
        cs_wr(10, uw(16'h00A0, JMP, 4));
        cs_wr(5,  uw(16'h0050, BRN, 20));
        cs_wr(20, uw(16'h0200, JMP, 5));
        cs_wr(6,  uw(16'h0060, JMP, 2));
        cs_wr(2,  uw(16'h0022, CALL, 12));
        cs_wr(12, uw(16'h00C0, RET, 0));
        cs_wr(3,  uw(16'h0033, RET, 0));
        bus.flag_z_i = 1'b1;
        do_start();
        chk("br_resume", bus.upc_o, 1);
        step();
        chk("br_upc4",  bus.upc_o,  4);
        chk("br_ctrl4", bus.ctrl_o, 16'h0040);
        step();
        chk("brz_taken", bus.upc_o, 10);
        step();
        chk("br_back4", bus.upc_o, 4);
        bus.flag_z_i = 1'b0;
        bus.flag_n_i = 1'b1;
        step();
        chk("brz_fall", bus.upc_o, 5);
        step();
        chk("brn_taken", bus.upc_o, 20);
        bus.flag_n_i = 1'b0;
        step();
        chk("br_back5", bus.upc_o, 5);
        step();
        chk("brn_fall", bus.upc_o, 6);
        step();
        chk("call_upc2", bus.upc_o, 2);
        chk("call_sp0",  bus.sp_o,  0);
        step();
        chk("call_upc12", bus.upc_o, 12);
        chk("call_sp1",   bus.sp_o,  1);
        step();
        chk("ret_upc3",  bus.upc_o,  3);
        chk("ret_sp0",   bus.sp_o,   0);
        chk("ret_ctrl3", bus.ctrl_o, 16'h0033);
        step();
        chk("unf_fault", bus.fault_o, 1);
        chk("unf_busy",  bus.busy_o,  0);
        chk("unf_ctrl",  bus.ctrl_o,  0);
        chk("unf_upc",   bus.upc_o,   3);
        bus.start = 1'b1; bus.stop = 1'b1;
        step();
        bus.start = 1'b0; bus.stop = 1'b0;
        chk("fault_sticky", bus.fault_o, 1);
        bus.clear_fault = 1'b1;
        step();
        bus.clear_fault = 1'b0;
        chk("clr_fault", bus.fault_o, 0);
        chk("clr_busy",  bus.busy_o,  0);
        chk("clr_upc",   bus.upc_o,   0);

        // Stack overflow
        cs_wr(0, uw(16'h0100, CALL, 0));
        do_start();
        chk("ovf_sp0", bus.sp_o, 0);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("ovf_sp", bus.sp_o, i);
        end
        chk("ovf_ctrl_run", bus.ctrl_o, 16'h0100);
        step();
        chk("ovf_fault", bus.fault_o, 1);
        chk("ovf_busy",  bus.busy_o,  0);
        chk("ovf_ctrl",  bus.ctrl_o,  0);
        chk("ovf_upc",   bus.upc_o,   0);
        chk("ovf_sp4",   bus.sp_o,    4);
        cs_wr(0, uw(16'hFFFF, JMP, 0));
        bus.clear_fault = 1'b1;
        step();
        bus.clear_fault = 1'b0;
        chk("ovf_clr_fault", bus.fault_o, 0);
        chk("ovf_clr_sp",    bus.sp_o,    0);
        do_start();
        chk("fault_wr_ignored", bus.ctrl_o, 16'h0100);
        do_stop();
        chk("stop_hold_upc", bus.upc_o, 0);
        chk("stop_hold_sp",  bus.sp_o,  0);

        // Reset mid-run, writes ignored in RUN, start+stop collision
        cs_wr(0, uw(16'h0100, CALL, 7));
        cs_wr(7, uw(16'h0700, JMP, 7));
        do_start();
        step();
        chk("r_upc7",  bus.upc_o,  7);
        chk("r_sp1",   bus.sp_o,   1);
        cs_wr(7, uw(16'hFFFF, JMP, 0));
        chk("run_wr_ignored", bus.ctrl_o, 16'h0700);
        #2 rst = 1'b1;
        #1;
        chk("arst_upc",  bus.upc_o,  0);
        chk("arst_sp",   bus.sp_o,   0);
        chk("arst_ctrl", bus.ctrl_o, 0);
        chk("arst_busy", bus.busy_o, 0);
        step();
        rst = 1'b0;
        do_start();
        chk("rerun_ctrl0", bus.ctrl_o, 16'h0100);
        step();
        chk("rerun_upc7",  bus.upc_o,  7);
        chk("rerun_ctrl7", bus.ctrl_o, 16'h0700);
        do_stop();
        bus.start = 1'b1; bus.stop = 1'b1;
        step();
        bus.start = 1'b0; bus.stop = 1'b0;
        chk("startstop_idle", bus.busy_o, 0);
        chk("startstop_upc",  bus.upc_o,  7);
        cs_wr(7, uw(16'h0700, MAP, 0));
        do_start();
        step();
        chk("map_reset", bus.upc_o, 0);
        do_stop();

`ifdef MICROSEQ_STALL_EN
        cs_wr(0, uw(16'h0100, JMP, 5));
        cs_wr(5, uw(16'h0555, INC, 0));
        cs_wr(6, uw(16'h0666, JMP, 6));
        do_start();
        step();
        chk("st_upc5", bus.upc_o, 5);
        bus.stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("st_hold_upc",  bus.upc_o,  5);
            chk("st_hold_ctrl", bus.ctrl_o, 16'h0555);
        end
        bus.stall_i = 1'b0;
        step();
        chk("st_resume", bus.upc_o, 6);
        bus.stall_i = 1'b1;
        do_stop();
        bus.stall_i = 1'b0;
        chk("st_stop_busy", bus.busy_o, 0);
        chk("st_stop_upc",  bus.upc_o,  6);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/microseq_ctrl.md
Name: microseq_ctrl

Overview:
Parametrised, writable-control-store microprogram sequencer. It is the next-generation control unit for our microprogrammed CPUs. It replaces the fixed address ROM, preset counter, vertical microcode ROM and decoder with one block, adding:
- a loadable control store and opcode map;
- conditional branches and a micro-subroutine stack;
- a run/idle/fault state machine.

It emits a horizontal control word to the datapath every cycle.

Parameters:
- UADDR_W, 5, micro-address width; control store depth = 2**UADDR_W.
- OPC_W, 4, macro-opcode width; map table depth = 2**OPC_W.
- CTRL_W, 16, control-word width driven to the datapath.
- STACK_DEPTH, 4, micro-return stack entries (>=1).
- Derived: UWORD_W = CTRL_W+3+UADDR_W.
- Derived: SP_W = $clog2(STACK_DEPTH)+1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  pulse: IDLE->RUN.
- stop  in  1  pulse: RUN->IDLE.
- clear_fault  in  1  pulse: FAULT->IDLE.
- cs_we  in  1  control-store write enable.
- cs_waddr  in  UADDR_W  control-store write address.
- cs_wdata  in  UWORD_W  microword to write.
- map_we  in  1  map-table write enable.
- map_waddr  in  OPC_W  opcode to map.
- map_wdata  in  UADDR_W  routine start address.
- opcode_i  in  OPC_W  opcode from the instruction register.
- flag_z_i  in  1  ALU zero flag.
- flag_n_i  in  1  ALU negative flag.
- ctrl_o  out  CTRL_W  control word.
- upc_o  out  UADDR_W  current micro-PC.
- sp_o  out  SP_W  stack occupancy.
- busy_o  out  1  state==RUN.
- fault_o  out  1  state==FAULT.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; upc=0; sp=0; map table all 0.
  - ctrl_o=0, busy_o=0, fault_o=0.
  - Control store is not reset.
- Microword layout:
  - [UWORD_W-1 -: CTRL_W] = ctrl.
  - [UADDR_W+2:UADDR_W] = seq op.
  - [UADDR_W-1:0] = target.
- Outputs and read path:
  - ctrl_o = cs[upc].ctrl, combinational asynchronous read, when state==RUN; otherwise 0.
  - Zero latency from upc to ctrl_o.
- Sequencing: on each rising edge in RUN, the seq op of cs[upc] sets the next upc:
  - 0 INC: upc+1, wraps 2**UADDR_W-1 -> 0.
  - 1 JMP: target.
  - 2 MAP: map[opcode_i].
  - 3 BRZ: flag_z_i ? target : upc+1.
  - 4 BRN: flag_n_i ? target : upc+1.
  - 5 CALL: push upc+1 (wrapped), sp+1, upc=target.
  - 6 RET: pop into upc, sp-1.
  - 7 FETCH: upc=0.
- State machine:
  - IDLE->RUN on start; upc is kept, so execution resumes.
  - RUN->IDLE on stop; the microword at the current upc is not sequenced, and upc/sp are held.
  - start and stop together: stop wins. start in RUN is ignored. stop in IDLE is ignored.
  - RUN->FAULT on:
    - CALL with sp==STACK_DEPTH (overflow), or
    - RET with sp==0 (underflow).
    - In that cycle upc and stack are unchanged.
  - FAULT->IDLE on clear_fault; upc=0, sp=0. start and stop are ignored in FAULT.
- Write ports:
  - cs_we and map_we are honoured only in IDLE; ignored in RUN/FAULT.
  - Writes are synchronous and visible from the next cycle.
  - Both may write in the same cycle.
- Reset mid-run aborts immediately; stack contents are discarded.

Optional Feature:
- Macro: MICROSEQ_STALL_EN.
- Defined:
  - Adds input stall_i (1 bit).
  - When stall_i=1 in RUN: upc, sp and stack hold, and ctrl_o keeps presenting cs[upc].ctrl (memory wait states).
  - stop and rst override the stall.
  - FAULT detection is evaluated only on non-stalled cycles.
- Undefined: no stall_i port; the sequencer never stalls.

Test Plan:
1. Basic sequencing:
   - Stimulus: in IDLE write cs[0]={0001,INC}, cs[1]={0002,MAP}, cs[8]={0004,JMP,0}; map[3]=8; opcode_i=3; start.
   - Required: upc_o 0,1,8,0,1; ctrl_o 0001,0002,0004,0001.
2. Conditional branches:
   - Stimulus: cs[4]={BRZ,10} with flag_z_i=1.
   - Required: next upc_o=10; with flag_z_i=0, next upc_o=5. Same check for BRN with flag_n_i.
3. Subroutine call/return:
   - Stimulus: cs[2]={CALL,12}, cs[12]={RET}.
   - Required: upc_o 2,12,3; sp_o 0,1,0.
4. Stack overflow and recovery:
   - Stimulus: STACK_DEPTH=4, cs[0]={CALL,0}.
   - Required: after 4 calls sp_o=4; 5th -> fault_o=1, busy_o=0, ctrl_o=0, upc_o=0 held.
   - Then clear_fault -> fault_o=0, sp_o=0, IDLE.
5. Reset, ignored writes, stop/start:
   - Stimulus: rst at upc_o=7 in RUN.
   - Required: same cycle upc_o=0, sp_o=0, ctrl_o=0, busy_o=0.
   - cs_we pulses during RUN leave contents unchanged (checked by re-running).
   - start+stop together in IDLE -> stays IDLE.
6. Stall (MICROSEQ_STALL_EN):
   - Stimulus: stall_i=1 for 3 cycles at upc_o=5.
   - Required: upc_o stays 5 and ctrl_o stays constant, then resumes to 6.
   - stop during stall -> IDLE next cycle.
